// File: rtl/xs3_pkg.sv
// ----------------------------------------------------------------------------
// xs3_pkg
// Shared definitions for the Excess-3 decimal path.
//   DIG_W            : width of one binary-coded decimal digit
//   DEC_MAX          : largest legal decimal digit value
//   xs3_acc_state_t  : accumulator FSM states (ACC collects digits, HOLD
//                      presents the finished word)
//   clog2_dec(n)     : minimum result width that holds any n-digit decimal
// ----------------------------------------------------------------------------
package xs3_pkg;

  localparam int DIG_W   = 4;
  localparam int DEC_MAX = 9;

  typedef enum logic [0:0] {
    ACC  = 1'b0,
    HOLD = 1'b1
  } xs3_acc_state_t;

  // Smallest b with 2^b > 10^n - 1.
  function automatic int clog2_dec(input int n);
    longint unsigned max_v;
    int              b;
    max_v = 1;
    for (int i = 0; i < n; i++) begin
      max_v = max_v * 10;
    end
    max_v = max_v - 1;
    b = 0;
    while ((longint'(1) << b) <= max_v) begin
      b++;
    end
    return b;
  endfunction

endpackage

// File: rtl/dec_mac.sv
// ----------------------------------------------------------------------------
// dec_mac
// Combinational decimal multiply-accumulate: mac = acc*10 + dig, built from
// shifts and adds, truncated to RES_W bits.
//   acc : running binary value (RES_W)
//   dig : decimal digit to append (DIG_W)
//   mac : acc*10 + dig (RES_W)
// ----------------------------------------------------------------------------
module dec_mac
  import xs3_pkg::*;
#(
  parameter int RES_W = 14
) (
  input  logic [RES_W-1:0] acc,
  input  logic [DIG_W-1:0] dig,
  output logic [RES_W-1:0] mac
);

  // acc*10 == acc*8 + acc*2
  assign mac = (acc << 3) + (acc << 1) + RES_W'(dig);

endmodule

// File: rtl/xs3_dec_accum.sv
// ----------------------------------------------------------------------------
// xs3_dec_accum
// Assembles a multi-digit decimal word (MSD first) into a binary value.
//
// Handshakes (both sides): a transfer happens on a rising edge where valid
// and ready are both 1. The source holds its payload stable until that edge;
// ready never depends on the partner's valid.
//
// Ports
//   clk, rst      : clock, synchronous active-high reset
//   dig_valid     : digit present            dig_ready : stage accepts digit
//   dig           : binary digit value       dig_invalid : converter flag
//   dig_last      : final digit of the word
//   res_valid     : result word present      res_ready : consumer accepts
//   result        : binary value (0 when the word had err or ovf)
//   res_err       : at least one bad digit   res_ovf : more than NDIGITS digits
//   dbg_state     : current FSM state
// ----------------------------------------------------------------------------
module xs3_dec_accum
  import xs3_pkg::*;
#(
  parameter int NDIGITS = 4,
  parameter int RES_W   = 14
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 dig_valid,
  output logic                 dig_ready,
  input  logic [DIG_W-1:0]     dig,
  input  logic                 dig_invalid,
  input  logic                 dig_last,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [RES_W-1:0]     result,
  output logic                 res_err,
  output logic                 res_ovf,
  output xs3_acc_state_t       dbg_state
);

  localparam int CNT_W = $clog2(NDIGITS + 1);

  generate
    if (RES_W < clog2_dec(NDIGITS)) begin : g_width_check
      $error("xs3_dec_accum: RES_W too small for NDIGITS decimal digits");
    end
  endgenerate

  xs3_acc_state_t   state_q, state_d;
  logic [RES_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             ovf_q, ovf_d;
  logic [RES_W-1:0] result_q, result_d;
  logic             res_err_q, res_err_d;
  logic             res_ovf_q, res_ovf_d;

  logic [RES_W-1:0] mac;
  logic             dig_bad;
  logic             dig_fire;
  logic [RES_W-1:0] acc_upd;
  logic [CNT_W-1:0] cnt_upd;
  logic             err_upd;
  logic             ovf_upd;

  dec_mac #(.RES_W(RES_W)) u_mac (
    .acc (acc_q),
    .dig (dig),
    .mac (mac)
  );

  assign dig_bad = dig_invalid | (dig > DIG_W'(DEC_MAX));

  // Post-update accumulator view for the digit being offered this cycle.
  always_comb begin
    acc_upd = acc_q;
    cnt_upd = cnt_q;
    err_upd = err_q;
    ovf_upd = ovf_q;
    if (dig_bad) begin
      err_upd = 1'b1;
    end else if (cnt_q < CNT_W'(NDIGITS)) begin
      acc_upd = mac;
      cnt_upd = cnt_q + 1'b1;
    end else begin
      // Extra digit beyond capacity: only flag it, keep what we have.
      ovf_upd = 1'b1;
    end
  end

  assign dig_fire = (state_q == ACC) && dig_valid;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    ovf_d     = ovf_q;
    result_d  = result_q;
    res_err_d = res_err_q;
    res_ovf_d = res_ovf_q;
    dig_ready = 1'b0;
    res_valid = 1'b0;
    unique case (state_q)
      ACC: begin
        dig_ready = 1'b1;
        if (dig_fire) begin
          if (dig_last) begin
            result_d  = (err_upd || ovf_upd) ? '0 : acc_upd;
            res_err_d = err_upd;
            res_ovf_d = ovf_upd;
            acc_d     = '0;
            cnt_d     = '0;
            err_d     = 1'b0;
            ovf_d     = 1'b0;
            state_d   = HOLD;
          end else begin
            acc_d = acc_upd;
            cnt_d = cnt_upd;
            err_d = err_upd;
            ovf_d = ovf_upd;
          end
        end
      end
      HOLD: begin
        res_valid = 1'b1;
        // Digit side stays closed this cycle; reopening happens after the edge.
        if (res_ready) begin
          state_d = ACC;
        end
      end
      default: begin
        state_d = ACC;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ACC;
      acc_q     <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      ovf_q     <= 1'b0;
      result_q  <= '0;
      res_err_q <= 1'b0;
      res_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      ovf_q     <= ovf_d;
      result_q  <= result_d;
      res_err_q <= res_err_d;
      res_ovf_q <= res_ovf_d;
    end
  end

  assign result    = result_q;
  assign res_err   = res_err_q;
  assign res_ovf   = res_ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_xs3_dec_accum.sv
// ----------------------------------------------------------------------------
// tb_xs3_dec_accum
// Bench for xs3_dec_accum: directed words from the test plan plus random
// words, each scored against a plain arithmetic model of the word.
// ----------------------------------------------------------------------------
module tb_xs3_dec_accum;
  import xs3_pkg::*;

  localparam int NDIGITS = 4;
  localparam int RES_W   = 14;
  localparam int W       = RES_W + 2;
  localparam int TMO     = 50;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             dig_valid = 1'b0;
  logic             dig_ready;
  logic [3:0]       dig = '0;
  logic             dig_invalid = 1'b0;
  logic             dig_last = 1'b0;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [RES_W-1:0] result;
  logic             res_err;
  logic             res_ovf;
  xs3_acc_state_t   dbg_state;

  xs3_dec_accum #(.NDIGITS(NDIGITS), .RES_W(RES_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .dig_valid   (dig_valid),
    .dig_ready   (dig_ready),
    .dig         (dig),
    .dig_invalid (dig_invalid),
    .dig_last    (dig_last),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .result      (result),
    .res_err     (res_err),
    .res_ovf     (res_ovf),
    .dbg_state   (dbg_state)
  );

  // scoreboard: {ovf, err, result}
  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // word under construction
  int         w_len;
  logic [3:0] w_dig[16];
  bit         w_inv[16];
  int         w_gap_max = 0;

  // Reference: decimal value of the good digits, counted against capacity.
  task automatic model_word();
    int  val;
    int  good;
    bit  err;
    bit  ovf;
    val = 0; good = 0; err = 0; ovf = 0;
    for (int i = 0; i < w_len; i++) begin
      if (w_inv[i] || w_dig[i] > 9) begin
        err = 1;
      end else if (good < NDIGITS) begin
        val = val * 10 + int'(w_dig[i]);
        good++;
      end else begin
        ovf = 1;
      end
    end
    if (err || ovf) val = 0;
    exp_q.push_back({ovf, err, RES_W'(val)});
  endtask

  task automatic send_word();
    int t;
    for (int i = 0; i < w_len; i++) begin
      if (w_gap_max > 0) begin
        dig_valid = 1'b0;
        repeat ($urandom_range(0, w_gap_max)) begin
          @(posedge clk); #1;
        end
      end
      dig_valid   = 1'b1;
      dig         = w_dig[i];
      dig_invalid = w_inv[i];
      dig_last    = (i == w_len - 1);
      t = 0;
      while (!dig_ready && t < TMO) begin
        @(posedge clk); #1;
        t++;
      end
      if (t >= TMO) begin
        n_bad++;
        $display("FAIL dig_accept_timeout: dig_ready=%0b after %0d cycles, required 1", dig_ready, t);
      end
      n_cmp++;
      @(posedge clk); #1;
      dig_valid = 1'b0;
      dig_last  = 1'b0;
      if (i != w_len - 1) begin
        if (dig_ready !== 1'b1 || res_valid !== 1'b0) begin
          n_bad++;
          $display("FAIL mid_word_hs: dig_ready=%0b res_valid=%0b, required 1/0", dig_ready, res_valid);
        end
        n_cmp++;
      end
    end
  endtask

  task automatic set_word(input int len, input logic [3:0] d0, input logic [3:0] d1,
                          input logic [3:0] d2, input logic [3:0] d3, input logic [3:0] d4);
    w_len = len;
    w_dig[0] = d0; w_dig[1] = d1; w_dig[2] = d2; w_dig[3] = d3; w_dig[4] = d4;
    for (int i = 0; i < 16; i++) w_inv[i] = 1'b0;
  endtask

  // Called right after the last digit's acceptance edge (+1).
  task automatic recv_result(input int delay, input bit noise);
    logic [W-1:0] exp;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard_empty: queue size 0, required >0");
      n_cmp++;
      return;
    end
    exp = exp_q.pop_front();
    if (res_valid !== 1'b1 || dig_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL latency: res_valid=%0b dig_ready=%0b, required 1/0", res_valid, dig_ready);
    end
    n_cmp++;
    if ({res_ovf, res_err, result} !== exp) begin
      n_bad++;
      $display("FAIL result: ovf=%0b err=%0b result=%0d, required ovf=%0b err=%0b result=%0d",
               res_ovf, res_err, result, exp[W-1], exp[W-2], exp[RES_W-1:0]);
    end
    n_cmp++;
    for (int k = 0; k < delay; k++) begin
      if (noise) begin
        dig_valid = 1'b1;
        dig       = 4'($urandom_range(0, 9));
        dig_last  = 1'b1;
      end
      @(posedge clk); #1;
      if (res_valid !== 1'b1 || dig_ready !== 1'b0 || {res_ovf, res_err, result} !== exp) begin
        n_bad++;
        $display("FAIL hold_stable: res_valid=%0b dig_ready=%0b out=%h, required 1/0/%h",
                 res_valid, dig_ready, {res_ovf, res_err, result}, exp);
      end
      n_cmp++;
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    dig_valid = 1'b0;
    dig_last  = 1'b0;
    if (res_valid !== 1'b0 || dig_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL take_release: res_valid=%0b dig_ready=%0b, required 0/1", res_valid, dig_ready);
    end
    n_cmp++;
  endtask

  task automatic check_reset_outputs(input string name);
    if (dig_ready !== 1'b1 || res_valid !== 1'b0 || result !== '0 ||
        res_err !== 1'b0 || res_ovf !== 1'b0 || dbg_state !== ACC) begin
      n_bad++;
      $display("FAIL %s: rdy=%0b vld=%0b res=%0d err=%0b ovf=%0b st=%0d, required 1/0/0/0/0/0",
               name, dig_ready, res_valid, result, res_err, res_ovf, dbg_state);
    end
    n_cmp++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_outputs("reset_state");
  endtask

  task automatic test_basic_words();
    set_word(4, 1, 2, 3, 4, 0); model_word(); send_word(); recv_result(0, 0);
    set_word(3, 0, 0, 7, 0, 0); model_word(); send_word(); recv_result(0, 0);
    set_word(1, 9, 0, 0, 0, 0); model_word(); send_word(); recv_result(1, 0);
  endtask

  task automatic test_error_words();
    set_word(3, 5, 6, 1, 0, 0); w_inv[1] = 1'b1;
    model_word(); send_word(); recv_result(0, 0);
    set_word(2, 4, 2, 0, 0, 0); model_word(); send_word(); recv_result(0, 0);
    set_word(2, 3, 12, 0, 0, 0); model_word(); send_word(); recv_result(0, 0);
  endtask

  task automatic test_overflow();
    set_word(5, 1, 2, 3, 4, 5); model_word(); send_word(); recv_result(0, 0);
    set_word(4, 9, 9, 9, 9, 0); model_word(); send_word(); recv_result(0, 0);
  endtask

  task automatic test_hold_and_reset();
    set_word(2, 6, 1, 0, 0, 0); model_word(); send_word(); recv_result(5, 1);
    // Partial word then reset: nothing must come out of it.
    dig_valid = 1'b1; dig = 4'd3; dig_invalid = 1'b0; dig_last = 1'b0;
    @(posedge clk); #1;
    dig = 4'd5;
    @(posedge clk); #1;
    dig_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_outputs("reset_mid_word");
    set_word(1, 8, 0, 0, 0, 0); model_word(); send_word(); recv_result(0, 0);
    // Reset while a result is pending.
    set_word(2, 7, 7, 0, 0, 0); send_word();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_outputs("reset_in_hold");
    set_word(2, 2, 5, 0, 0, 0); model_word(); send_word(); recv_result(0, 0);
  endtask

  task automatic test_random();
    w_gap_max = 2;
    for (int n = 0; n < 40; n++) begin
      w_len = $urandom_range(1, 6);
      for (int i = 0; i < w_len; i++) begin
        int r;
        r = $urandom_range(0, 19);
        w_inv[i] = (r == 0);
        w_dig[i] = (r == 1) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      end
      model_word();
      send_word();
      recv_result($urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
    w_gap_max = 0;
  endtask

  initial begin
    test_reset();
    test_basic_words();
    test_error_words();
    test_overflow();
    test_hold_and_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
